ahb_apb_bridge_nslv: RTL

Parametrised AHB-Lite to APB bridge that decodes one AHB slave port onto `NUM_SLV` APB slaves with individual `PSEL` lines. It is the next-generation bridge for the peripheral subsystem: configurable address and data width, `PREADY` wait states, `PSLVERR` mapped to a two-cycle AHB `ERROR` response, decode-miss errors, and an optional APB timeout. It sits between the AHB interconnect and the APB peripheral cluster, with a single clock domain.

---
 rtl/ahb_apb_bridge_nslv.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_apb_bridge_nslv.sv
// ahb_apb_bridge_nslv: AHB-Lite slave port bridged onto NUM_SLV APB slaves with one-hot PSEL.
// Define AHB_APB_TIMEOUT_EN to abort APB accesses that stall for TIMEOUT_CYC cycles.
`default_nettype none

module ahb_apb_bridge_nslv #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int NUM_SLV       = 4,
    parameter int SLV_ADDR_BITS = 12,
    parameter int TIMEOUT_CYC   = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic                      HWRITE,
    input  logic [1:0]                HTRANS,
    input  logic [DATA_W-1:0]         HWDATA,
    input  logic                      HREADYin,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADY,
    output logic                      HRESP,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int IDX_W = ADDR_W - SLV_ADDR_BITS;
    // Compare width is wide enough for both the address index and any slave number up to 63.
    localparam int CMP_W = (IDX_W > 6) ? IDX_W : 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state;

    logic                accept;
    logic [CMP_W-1:0]    idx_cmp;
    logic [NUM_SLV-1:0]  dec_onehot;
    logic                dec_hit;
    logic                slv_ready;
    logic                slv_err;
    logic [DATA_W-1:0]   prdata_mux;
    logic                tmo_hit;
    logic                unused_ok;

    // Only IDLE accepts; an address phase seen during ERR2 is the one the master cancels.
    assign accept  = HSEL & HTRANS[1] & HREADYin & HREADY & (state == ST_IDLE);
    assign idx_cmp = CMP_W'(HADDR[ADDR_W-1:SLV_ADDR_BITS]);

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            dec_onehot[i] = (idx_cmp == CMP_W'(i));
        end
    end

    assign dec_hit = |dec_onehot;

    // PSEL is one-hot during SETUP/ACCESS, so it doubles as the mux select for the active slave.
    assign slv_ready = |(PREADY & PSEL);
    assign slv_err   = |(PSLVERR & PSEL);

    always_comb begin
        prdata_mux = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            prdata_mux = prdata_mux | (PRDATA[i*DATA_W +: DATA_W] & {DATA_W{PSEL[i]}});
        end
    end

`ifdef AHB_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;

    assign tmo_next = tmo_cnt + 1'b1;
    assign tmo_hit  = (tmo_next == TMO_W'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    assign unused_ok = ^{HTRANS[0], 32'(TIMEOUT_CYC)};

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            HREADY  <= 1'b1;
            HRESP   <= 1'b0;
            HRDATA  <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
`ifdef AHB_APB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    HRESP  <= 1'b0;
                    HREADY <= 1'b1;
                    if (accept) begin
                        HREADY <= 1'b0;
                        if (dec_hit) begin
                            PADDR  <= HADDR;
                            PWRITE <= HWRITE;
                            PSEL   <= dec_onehot;
                            state  <= ST_SETUP;
                        end else begin
                            HRESP <= 1'b1;
                            state <= ST_ERR1;
                        end
                    end
                end

                // HWDATA belongs to the data phase, which is the SETUP cycle.
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    PWDATA  <= HWDATA;
`ifdef AHB_APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (slv_ready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (slv_err) begin
                            HRESP <= 1'b1;
                            state <= ST_ERR1;
                        end else begin
                            HREADY <= 1'b1;
                            if (!PWRITE) begin
                                HRDATA <= prdata_mux;
                            end
                            state <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        HRESP   <= 1'b1;
                        state   <= ST_ERR1;
                    end
`ifdef AHB_APB_TIMEOUT_EN
                    if (!slv_ready) begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end

                // Two-cycle ERROR: HREADY low with HRESP, then HREADY high with HRESP.
                ST_ERR1: begin
                    HRESP  <= 1'b1;
                    HREADY <= 1'b1;
                    state  <= ST_ERR2;
                end

                ST_ERR2: begin
                    HRESP  <= 1'b0;
                    HREADY <= 1'b1;
                    state  <= ST_IDLE;
                end

                default: begin
                    PSEL    <= '0;
                    PENABLE <= 1'b0;
                    HRESP   <= 1'b0;
                    HREADY  <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
